// File: rtl/fifo_port_arbiter_pkg.sv
// Shared definitions for the two-master FIFO write/read arbiter.
package fifo_port_arbiter_pkg;

    localparam int DW_DEF    = 8;
    localparam int DEPTH_DEF = 16;

    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t WR     = 3'd1;
    localparam state_t RD     = 3'd2;
    localparam state_t RDV    = 3'd3;
    localparam state_t SETTLE = 3'd4;

endpackage

// File: rtl/fifo_port_arbiter_if.sv
// Requester, reader and FIFO-side signals of the arbiter; slave is the arbiter's view.
interface fifo_port_arbiter_if #(
    parameter int DW    = fifo_port_arbiter_pkg::DW_DEF,
    parameter int DEPTH = fifo_port_arbiter_pkg::DEPTH_DEF
);
    logic                     req0, req1;
    logic [DW-1:0]            din0, din1;
    logic                     ack0, ack1;
    logic                     rd_req, rd_ack, rd_valid;
    logic                     fifo_wr, fifo_rd;
    logic [DW-1:0]            fifo_din;
    logic                     fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0]   occupancy;

    modport slave (
        input  req0, req1, din0, din1, rd_req, fifo_full, fifo_empty,
        output ack0, ack1, rd_ack, rd_valid, fifo_wr, fifo_rd, fifo_din, occupancy
    );

    modport master (
        output req0, req1, din0, din1, rd_req, fifo_full, fifo_empty,
        input  ack0, ack1, rd_ack, rd_valid, fifo_wr, fifo_rd, fifo_din, occupancy
    );
endinterface

// File: rtl/fifo_port_arbiter_rr_arb2.sv
// Two-way round-robin grant: a contested grant goes to the requester that did not win last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end
endmodule

// File: rtl/fifo_port_arbiter.sv
// Serialises two write masters and one reader onto a single FIFO port, reads first.
import fifo_port_arbiter_pkg::*;

module fifo_port_arbiter #(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    fifo_port_arbiter_if.slave bus
);
    localparam int OW = $clog2(DEPTH) + 1;

    state_t        state, nxt;
    logic [1:0]    grant;
    logic          last_grant, gidx;
    logic [DW-1:0] din_q;
    logic [OW-1:0] occ;
    logic          arb_pt, rd_go, wr_go, enter_wr;

    rr_arb2 u_arb (
        .req   ({bus.req1, bus.req0}),
        .last  (last_grant),
        .grant (grant)
    );

    // SETTLE doubles as an arbitration point so back-to-back writes run every 2 cycles
    assign arb_pt   = (state == IDLE) || (state == SETTLE);
    assign rd_go    = bus.rd_req && !bus.fifo_empty && (occ != '0);
    assign wr_go    = (bus.req0 || bus.req1) && !bus.fifo_full && (occ < OW'(DEPTH));
    assign enter_wr = arb_pt && !rd_go && wr_go;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE, SETTLE: begin
                if (rd_go)      nxt = RD;
                else if (wr_go) nxt = WR;
                else            nxt = IDLE;
            end
            WR:      nxt = SETTLE;
            RD:      nxt = RDV;
            RDV:     nxt = SETTLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.fifo_wr  = 1'b0;
        bus.fifo_rd  = 1'b0;
        bus.ack0     = 1'b0;
        bus.ack1     = 1'b0;
        bus.rd_ack   = 1'b0;
        bus.rd_valid = 1'b0;
        case (state)
            WR: begin
                bus.fifo_wr = 1'b1;
                bus.ack0    = !gidx;
                bus.ack1    = gidx;
            end
            RD: begin
                bus.fifo_rd = 1'b1;
                bus.rd_ack  = 1'b1;
            end
            RDV:     bus.rd_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= 1'b1;
            gidx       <= 1'b0;
            din_q      <= '0;
        end else if (enter_wr) begin
            last_grant <= grant[1];
            gidx       <= grant[1];
            din_q      <= grant[1] ? bus.din1 : bus.din0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            occ <= '0;
        else if ((state == WR) && (occ < OW'(DEPTH)))
            occ <= occ + 1'b1;
        else if ((state == RD) && (occ != '0))
            occ <= occ - 1'b1;
    end

    assign bus.fifo_din  = din_q;
    assign bus.occupancy = occ;

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// Directed bench for fifo_port_arbiter with a behavioural 16-entry FIFO status model.
module tb_fifo_port_arbiter;
    import fifo_port_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fifo_port_arbiter_if #(.DW(8), .DEPTH(16)) bus ();

    fifo_port_arbiter #(.DW(8), .DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int fcnt;
    assign bus.fifo_full  = (fcnt >= 16);
    assign bus.fifo_empty = (fcnt == 0);

    always @(posedge clk or negedge rst) begin
        if (!rst) fcnt <= 0;
        else if (bus.fifo_wr && fcnt < 16) fcnt <= fcnt + 1;
        else if (bus.fifo_rd && fcnt > 0) fcnt <= fcnt - 1;
    end

    int n_chk = 0, n_fail = 0;
    int n_ack0 = 0, n_ack1 = 0, n_rdack = 0, n_viol = 0, cyc = 0;
    logic [7:0] wr_data[$];
    logic       wr_who[$];
    int         wr_cyc[$];

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            if (bus.ack0)   n_ack0++;
            if (bus.ack1)   n_ack1++;
            if (bus.rd_ack) n_rdack++;
            if (bus.fifo_wr && bus.fifo_rd) n_viol++;
            if (bus.ack0 && bus.ack1)       n_viol++;
            if (bus.fifo_wr) begin
                wr_data.push_back(bus.fifo_din);
                wr_who.push_back(bus.ack1);
                wr_cyc.push_back(cyc);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.rd_req = 1'b0;
        bus.din0 = '0;   bus.din1 = '0;
        repeat (2) tick();
        rst = 1'b1;
    endtask

    function automatic logic sig(input int w);
        case (w)
            0:       return bus.ack0;
            1:       return bus.ack1;
            default: return bus.rd_ack;
        endcase
    endfunction

    task automatic wait_sig(input int w, input string tag, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!sig(w) && n < 20);
        if (!sig(w)) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wr_byte(input logic [7:0] d);
        int n;
        bus.din0 = d;
        bus.req0 = 1'b1;
        wait_sig(0, "wr_byte", n);
        bus.req0 = 1'b0;
    endtask

    initial begin
        int n, k, base, a0, a1, r0;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.rd_req = 1'b0;
        bus.din0 = '0;   bus.din1 = '0;

        // reset state
        repeat (2) tick();
        chk("rst_state", dut.state, IDLE);
        chk("rst_occ", bus.occupancy, 0);
        chk("rst_din", bus.fifo_din, 0);
        chk("rst_strobes", {bus.ack0, bus.ack1, bus.fifo_wr, bus.fifo_rd, bus.rd_ack, bus.rd_valid}, 0);
        rst = 1'b1;

        // single write
        bus.din0 = 8'hA5; bus.req0 = 1'b1;
        tick();
        chk("wr1_fifo_wr", bus.fifo_wr, 1);
        chk("wr1_ack0", bus.ack0, 1);
        chk("wr1_ack1", bus.ack1, 0);
        chk("wr1_din", bus.fifo_din, 8'hA5);
        chk("wr1_occ_before", bus.occupancy, 0);
        bus.req0 = 1'b0;
        tick();
        chk("wr1_occ_after", bus.occupancy, 1);
        chk("wr1_wr_done", bus.fifo_wr, 0);
        chk("wr1_settle", dut.state, SETTLE);
        tick();
        chk("wr1_idle", dut.state, IDLE);

        // contention: 0,1,0,1 every 2 cycles
        do_reset();
        base = wr_data.size();
        bus.din0 = 8'h11; bus.din1 = 8'h22;
        bus.req0 = 1'b1;  bus.req1 = 1'b1;
        k = 0; n = 0;
        while (k < 4 && n < 40) begin
            tick();
            n++;
            if (bus.ack0 || bus.ack1) k++;
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        if (k < 4) chk("cont_timeout", k, 4);
        repeat (2) tick();
        chk("cont_count", wr_data.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < wr_data.size()) begin
                chk($sformatf("cont_who%0d", i), wr_who[base+i], i % 2);
                chk($sformatf("cont_data%0d", i), wr_data[base+i], (i % 2) ? 8'h22 : 8'h11);
                if (i > 0) chk($sformatf("cont_gap%0d", i), wr_cyc[base+i] - wr_cyc[base+i-1], 2);
            end
        end
        chk("cont_occ", bus.occupancy, 4);

        // full: blocked write served after a read
        do_reset();
        base = wr_data.size();
        for (int i = 0; i < 16; i++) wr_byte(8'(i));
        repeat (2) tick();
        chk("full_occ", bus.occupancy, 16);
        chk("full_flag", bus.fifo_full, 1);
        if (base + 15 < wr_data.size()) chk("full_last_data", wr_data[base+15], 8'h0F);
        a1 = n_ack1;
        bus.din1 = 8'h77; bus.req1 = 1'b1;
        repeat (6) tick();
        chk("full_no_ack1", n_ack1 - a1, 0);
        chk("full_occ_hold", bus.occupancy, 16);
        bus.rd_req = 1'b1;
        wait_sig(2, "full_rd", n);
        bus.rd_req = 1'b0;
        tick();
        chk("full_rd_valid", bus.rd_valid, 1);
        wait_sig(1, "full_ack1", n);
        chk("full_ack1_within4", (n + 1) <= 4, 1);
        chk("full_ack1_din", bus.fifo_din, 8'h77);
        bus.req1 = 1'b0;
        tick();
        chk("full_occ_end", bus.occupancy, 16);

        // empty: read waits for data
        do_reset();
        r0 = n_rdack;
        bus.rd_req = 1'b1;
        repeat (5) tick();
        chk("empty_no_rdack", n_rdack - r0, 0);
        wr_byte(8'h3C);
        wait_sig(2, "empty_rd", n);
        chk("empty_occ_rd", bus.occupancy, 1);
        bus.rd_req = 1'b0;
        tick();
        chk("empty_rd_valid", bus.rd_valid, 1);
        chk("empty_rdack_gone", bus.rd_ack, 0);
        chk("empty_occ_after", bus.occupancy, 0);

        // simultaneous read and write: read first
        do_reset();
        wr_byte(8'h01); wr_byte(8'h02); wr_byte(8'h03);
        repeat (2) tick();
        chk("sim_occ3", bus.occupancy, 3);
        bus.rd_req = 1'b1; bus.din0 = 8'h5A; bus.req0 = 1'b1;
        tick();
        chk("sim_rd_first", {bus.rd_ack, bus.ack0}, 2'b10);
        bus.rd_req = 1'b0;
        tick();
        chk("sim_occ2", bus.occupancy, 2);
        wait_sig(0, "sim_wr", n);
        bus.req0 = 1'b0;
        tick();
        chk("sim_occ3_again", bus.occupancy, 3);

        // reset in the WR cycle
        do_reset();
        a0 = n_ack0;
        bus.din0 = 8'h99; bus.req0 = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        #3;
        chk("rstwr_ack0", bus.ack0, 0);
        chk("rstwr_occ", bus.occupancy, 0);
        chk("rstwr_state", dut.state, IDLE);
        repeat (2) tick();
        chk("rstwr_no_ack", n_ack0 - a0, 0);
        rst = 1'b1;
        wait_sig(0, "rstwr_rearb", n);
        chk("rstwr_rearb_lat", n, 1);
        chk("rstwr_din", bus.fifo_din, 8'h99);
        bus.req0 = 1'b0;
        tick();
        chk("rstwr_occ1", bus.occupancy, 1);

        chk("mutex_viol", n_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
